// File: rtl/kcpsm_port_hub_pkg.sv
// Shared definitions for the KCPSM port hub: default port map, peripheral
// channel indices and the interrupt FSM state encoding.
package kcpsm_port_hub_pkg;

    localparam logic [7:0] DEF_STAT_ADDR = 8'h0F;
    localparam logic [7:0] DEF_IN_BASE   = 8'h10;
    localparam logic [7:0] DEF_OUT_BASE  = 8'h20;
    localparam logic [7:0] DEF_RD_VAL    = 8'h00;

    // Peripheral channel indices within the input/output banks
    localparam int CH_RTC   = 0;
    localparam int CH_PS2   = 1;
    localparam int CH_VGA   = 2;
    localparam int CH_AUDIO = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_WAIT = 2'd2
    } irq_state_e;

endpackage

// File: rtl/kcpsm_port_hub_if.sv
// CPU-side port bus of the KCPSM port hub.
// Bus semantics: port_id is valid whenever a strobe is high; each strobe is a
// single-cycle qualifier with no backpressure. in_port is the registered
// image of port_id one clock earlier, so the CPU sees it on its INPUT cycle.
interface kcpsm_port_hub_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic [AW-1:0] port_id;
    logic [DW-1:0] out_port;
    logic          write_strobe;
    logic          k_write_strobe;
    logic          read_strobe;
    logic [DW-1:0] in_port;
    logic          interrupt;
    logic          interrupt_ack;

    modport master (
        output port_id, out_port, write_strobe, k_write_strobe, read_strobe,
        output interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, out_port, write_strobe, k_write_strobe, read_strobe,
        input  interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/kcpsm_port_hub_evt_flag_bank.sv
// Sticky event flags, interrupt mask, clear-on-read and the interrupt
// request FSM of the KCPSM port hub.
module kcpsm_port_hub_evt_flag_bank
    import kcpsm_port_hub_pkg::*;
#(
    parameter int N_EVT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_EVT-1:0] evt_in_i,
    input  logic             mask_we_i,
    input  logic [N_EVT-1:0] mask_wdata_i,
    input  logic             clr_en_i,
    input  logic [N_EVT-1:0] clr_bits_i,
    input  logic             irq_ack_i,
    output logic [N_EVT-1:0] flags_o,
    output logic [N_EVT-1:0] mask_o,
    output logic             irq_o,
    output irq_state_e       state_o
);

    logic [N_EVT-1:0] flags_q, flags_d;
    logic [N_EVT-1:0] mask_q, mask_d;
    irq_state_e       state_q, state_d;
    logic             pending;

    // Events are OR-ed in after the clear so a same-cycle event is never lost
    always_comb begin
        flags_d = flags_q;
        if (clr_en_i) begin
            flags_d = flags_q & ~clr_bits_i;
        end
        flags_d = flags_d | evt_in_i;
        mask_d  = mask_we_i ? mask_wdata_i : mask_q;
    end

    assign pending = |(flags_q & mask_q);

    always_comb begin
        state_d = state_q;
        irq_o   = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (pending) begin
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                irq_o = 1'b1;
                if (irq_ack_i) begin
                    state_d = IRQ_WAIT;
                end else if (mask_we_i && (mask_wdata_i == '0)) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_WAIT: begin
                // Re-arm only once every enabled flag has been cleared
                if (!pending) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
            mask_q  <= '0;
            state_q <= IRQ_IDLE;
        end else begin
            flags_q <= flags_d;
            mask_q  <= mask_d;
            state_q <= state_d;
        end
    end

    assign flags_o = flags_q;
    assign mask_o  = mask_q;
    assign state_o = state_q;

endmodule

// File: rtl/kcpsm_port_hub.sv
// KCPSM I/O port hub: registered read mux, registered output bank with
// OUTPUT/OUTPUTK decode, per-channel strobes and the event/interrupt bank.
module kcpsm_port_hub
    import kcpsm_port_hub_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter int            N_IN      = 12,
    parameter int            N_OUT     = 8,
    parameter int            N_EVT     = 4,
    parameter logic [AW-1:0] IN_BASE   = AW'(DEF_IN_BASE),
    parameter logic [AW-1:0] OUT_BASE  = AW'(DEF_OUT_BASE),
    parameter logic [AW-1:0] STAT_ADDR = AW'(DEF_STAT_ADDR),
    parameter logic [DW-1:0] DEF_RD    = DW'(DEF_RD_VAL)
) (
    input  logic                clk,
    input  logic                reset,
    kcpsm_port_hub_if.slave     bus,
    input  logic [N_IN*DW-1:0]  ch_in,
    output logic [N_IN-1:0]     rd_ack,
    output logic [N_OUT*DW-1:0] ch_out,
    output logic [N_OUT-1:0]    wr_pulse,
    input  logic [N_EVT-1:0]    evt_in,
    output irq_state_e          irq_state
);

    localparam logic [AW-1:0] MASK_ADDR = STAT_ADDR + AW'(1);

    logic [DW-1:0]       in_port_q, in_port_d;
    logic [N_IN-1:0]     rd_ack_q, rd_ack_d;
    logic [N_OUT*DW-1:0] ch_out_q, ch_out_d;
    logic [N_OUT-1:0]    wr_pulse_q, wr_pulse_d;

    logic                stat_sel, mask_sel;
    logic [N_EVT-1:0]    flags, mask;

    assign stat_sel = (bus.port_id == STAT_ADDR);
    assign mask_sel = (bus.port_id == MASK_ADDR);

    // Read mux and read acknowledges; status/mask shadow any overlapping channel
    always_comb begin
        in_port_d = DEF_RD;
        rd_ack_d  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (bus.port_id == AW'(IN_BASE + AW'(i))) begin
                in_port_d   = ch_in[i*DW +: DW];
                rd_ack_d[i] = bus.read_strobe;
            end
        end
        if (stat_sel) begin
            in_port_d              = '0;
            in_port_d[N_EVT-1:0]   = flags;
            rd_ack_d               = '0;
        end else if (mask_sel) begin
            in_port_d              = '0;
            in_port_d[N_EVT-1:0]   = mask;
            rd_ack_d               = '0;
        end
    end

    // OUTPUT decodes the full address; OUTPUTK only port_id[3:0] and loses to OUTPUT
    always_comb begin
        wr_pulse_d = '0;
        ch_out_d   = ch_out_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (bus.write_strobe) begin
                wr_pulse_d[i] = (bus.port_id == AW'(OUT_BASE + AW'(i))) &&
                                !stat_sel && !mask_sel;
            end else begin
                wr_pulse_d[i] = bus.k_write_strobe && (bus.port_id[3:0] == 4'(i));
            end
            if (wr_pulse_d[i]) begin
                ch_out_d[i*DW +: DW] = bus.out_port;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_port_q  <= DEF_RD;
            rd_ack_q   <= '0;
            ch_out_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            in_port_q  <= in_port_d;
            rd_ack_q   <= rd_ack_d;
            ch_out_q   <= ch_out_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // The clear uses the status value the CPU is actually latching this cycle
    kcpsm_port_hub_evt_flag_bank #(
        .N_EVT (N_EVT)
    ) u_evt_flag_bank (
        .clk          (clk),
        .reset        (reset),
        .evt_in_i     (evt_in),
        .mask_we_i    (bus.write_strobe && mask_sel),
        .mask_wdata_i (bus.out_port[N_EVT-1:0]),
        .clr_en_i     (bus.read_strobe && stat_sel),
        .clr_bits_i   (in_port_q[N_EVT-1:0]),
        .irq_ack_i    (bus.interrupt_ack),
        .flags_o      (flags),
        .mask_o       (mask),
        .irq_o        (bus.interrupt),
        .state_o      (irq_state)
    );

    assign bus.in_port = in_port_q;
    assign rd_ack      = rd_ack_q;
    assign ch_out      = ch_out_q;
    assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_kcpsm_port_hub.sv
// Directed self-checking bench for kcpsm_port_hub with hand-computed expectations.
module tb_kcpsm_port_hub;
    import kcpsm_port_hub_pkg::*;

    logic        clk;
    logic        reset;
    logic [95:0] ch_in;
    logic [11:0] rd_ack;
    logic [63:0] ch_out;
    logic [7:0]  wr_pulse;
    logic [3:0]  evt_in;
    irq_state_e  irq_state;

    int n_cmp;
    int n_err;

    kcpsm_port_hub_if #(.DW(8), .AW(8)) bus ();

    kcpsm_port_hub dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ch_in     (ch_in),
        .rd_ack    (rd_ack),
        .ch_out    (ch_out),
        .wr_pulse  (wr_pulse),
        .evt_in    (evt_in),
        .irq_state (irq_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data,
                             input logic ws, input logic ks);
        bus.port_id        = addr;
        bus.out_port       = data;
        bus.write_strobe   = ws;
        bus.k_write_strobe = ks;
        tick();
        bus.write_strobe   = 1'b0;
        bus.k_write_strobe = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.port_id        = 8'h00;
        bus.out_port       = 8'h00;
        bus.write_strobe   = 1'b0;
        bus.k_write_strobe = 1'b0;
        bus.read_strobe    = 1'b0;
        bus.interrupt_ack  = 1'b0;
        evt_in = 4'h0;
        for (int i = 0; i < 12; i++) ch_in[i*8 +: 8] = 8'h30 + 8'(i);
        ch_in[2*8 +: 8] = 8'h37;
        tick();
        tick();

        check_eq("rst_in_port", 64'(bus.in_port), 64'h00);
        check_eq("rst_irq", 64'(bus.interrupt), 64'h0);
        check_eq("rst_rd_ack", 64'(rd_ack), 64'h0);
        check_eq("rst_wr_pulse", 64'(wr_pulse), 64'h0);
        check_eq("rst_ch_out", ch_out, 64'h0);
        check_eq("rst_state", 64'(irq_state), 64'(IRQ_IDLE));

        reset = 1'b1;
        tick();

        // read mux and read acknowledge
        bus.port_id = 8'h12;
        tick();
        check_eq("rd_ch2", 64'(bus.in_port), 64'h37);
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        check_eq("rd_ack_ch2", 64'(rd_ack), 64'h004);
        tick();
        check_eq("rd_ack_clear", 64'(rd_ack), 64'h000);
        bus.port_id = 8'h1B;
        tick();
        check_eq("rd_ch11", 64'(bus.in_port), 64'h3B);
        bus.port_id = 8'h1C;
        tick();
        check_eq("rd_past_top", 64'(bus.in_port), 64'h00);

        // unmapped address
        bus.port_id = 8'h55;
        tick();
        check_eq("rd_unmapped", 64'(bus.in_port), 64'h00);
        cpu_write(8'h55, 8'hEE, 1'b1, 1'b0);
        check_eq("wr_unmapped_pulse", 64'(wr_pulse), 64'h0);
        check_eq("wr_unmapped_data", ch_out, 64'h0);

        // OUTPUT and OUTPUTK
        cpu_write(8'h23, 8'hA5, 1'b1, 1'b0);
        check_eq("wr_ch3_data", 64'(ch_out[3*8 +: 8]), 64'hA5);
        check_eq("wr_ch3_pulse", 64'(wr_pulse), 64'h08);
        tick();
        check_eq("wr_pulse_1cyc", 64'(wr_pulse), 64'h00);
        cpu_write(8'hF1, 8'h5A, 1'b0, 1'b1);
        check_eq("kwr_ch1_data", 64'(ch_out[1*8 +: 8]), 64'h5A);
        check_eq("kwr_ch1_pulse", 64'(wr_pulse), 64'h02);
        cpu_write(8'hF9, 8'h77, 1'b0, 1'b1);
        check_eq("kwr_ch9_ignored", 64'(wr_pulse), 64'h00);
        cpu_write(8'h55, 8'h99, 1'b1, 1'b1);
        check_eq("both_ws_wins_pulse", 64'(wr_pulse), 64'h00);
        check_eq("both_ws_wins_ch5", 64'(ch_out[5*8 +: 8]), 64'h00);
        cpu_write(8'h27, 8'hC3, 1'b1, 1'b1);
        check_eq("both_ch7_pulse", 64'(wr_pulse), 64'h80);
        cpu_write(8'h28, 8'h11, 1'b1, 1'b0);
        check_eq("wr_past_top", 64'(wr_pulse), 64'h00);
        check_eq("ch_out_bank", ch_out, 64'hC300_0000_A500_5A00);

        // mask, event, interrupt, ack, clear-on-read
        cpu_write(8'h10, 8'h03, 1'b1, 1'b0);
        tick();
        check_eq("rd_mask", 64'(bus.in_port), 64'h03);
        evt_in = 4'b0001;
        tick();
        evt_in = 4'b0000;
        check_eq("irq_not_yet", 64'(bus.interrupt), 64'h0);
        tick();
        check_eq("irq_raised", 64'(bus.interrupt), 64'h1);
        check_eq("state_req", 64'(irq_state), 64'(IRQ_REQ));
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        check_eq("irq_acked", 64'(bus.interrupt), 64'h0);
        check_eq("state_wait", 64'(irq_state), 64'(IRQ_WAIT));
        bus.port_id = 8'h0F;
        tick();
        check_eq("rd_status", 64'(bus.in_port), 64'h01);
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        check_eq("rd_ack_status_none", 64'(rd_ack), 64'h000);
        tick();
        check_eq("status_cleared", 64'(bus.in_port), 64'h00);
        check_eq("state_idle", 64'(irq_state), 64'(IRQ_IDLE));

        // event coinciding with the clearing read
        evt_in = 4'b0010;
        tick();
        evt_in = 4'b0000;
        tick();
        check_eq("irq_evt1", 64'(bus.interrupt), 64'h1);
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        check_eq("rd_status_evt1", 64'(bus.in_port), 64'h02);
        bus.read_strobe = 1'b1;
        evt_in = 4'b0010;
        tick();
        bus.read_strobe = 1'b0;
        evt_in = 4'b0000;
        tick();
        check_eq("set_wins_clear", 64'(bus.in_port), 64'h02);
        check_eq("still_wait", 64'(irq_state), 64'(IRQ_WAIT));
        check_eq("irq_low_wait", 64'(bus.interrupt), 64'h0);
        cpu_write(8'h0F, 8'hFF, 1'b1, 1'b0);
        tick();
        check_eq("stat_write_ignored", 64'(bus.in_port), 64'h02);
        cpu_write(8'h10, 8'h00, 1'b1, 1'b0);
        tick();
        check_eq("wait_to_idle", 64'(irq_state), 64'(IRQ_IDLE));
        cpu_write(8'h10, 8'h03, 1'b1, 1'b0);
        tick();
        check_eq("irq_reraised", 64'(bus.interrupt), 64'h1);
        cpu_write(8'h10, 8'h00, 1'b1, 1'b0);
        check_eq("mask0_in_req_irq", 64'(bus.interrupt), 64'h0);
        check_eq("mask0_in_req_state", 64'(irq_state), 64'(IRQ_IDLE));

        // asynchronous reset in the middle of a write
        bus.port_id      = 8'h21;
        bus.out_port     = 8'h44;
        bus.write_strobe = 1'b1;
        tick();
        check_eq("pre_rst_pulse", 64'(wr_pulse), 64'h02);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_pulse", 64'(wr_pulse), 64'h00);
        check_eq("mid_rst_ch_out", ch_out, 64'h0);
        check_eq("mid_rst_in_port", 64'(bus.in_port), 64'h00);
        check_eq("mid_rst_state", 64'(irq_state), 64'(IRQ_IDLE));
        bus.write_strobe = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_eq("post_rst_pulse", 64'(wr_pulse), 64'h00);
        check_eq("post_rst_ch_out", ch_out, 64'h0);
        bus.port_id = 8'h0F;
        tick();
        check_eq("post_rst_flags", 64'(bus.in_port), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
